cpu_clk_ctrl: RTL and testbench



---
 rtl/cpu_clk_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock/reset controller: derives clk_cpu from clk50M (free-run divider or
// debounced single-step) and stretches cpu_rst across real clk_cpu rising edges.
module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 25,
  parameter int RST_HOLD        = 4
) (
  input  logic                 clk50M,
  input  logic                 rst,
  input  logic                 clk_manual,
  input  logic                 single_step_mode,
  input  logic [CNT_WIDTH-1:0] cpu_speed,
  input  logic                 rom_selector,
  output logic                 clk_cpu,
  output logic                 clk_cpu_rise,
  output logic                 cpu_rst,
  output logic [15:0]          step_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HC_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_INIT = HC_W'(RST_HOLD);

  logic [1:0]           r_man_sync;
  logic [1:0]           r_mode_sync;
  logic [1:0]           r_rom_sync;
  logic                 r_mode_prev;
  logic                 r_rom_prev;
  logic [DB_W-1:0]      r_db_cnt;
  logic                 r_db_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_clk_cpu;
  logic                 r_clk_cpu_rise;
  logic [HC_W-1:0]      r_hc;
  logic                 r_cpu_rst;
  logic [15:0]          r_step_count;

  logic                 w_man_s;
  logic                 w_mode_s;
  logic                 w_rom_s;
  logic                 w_db_diff;
  logic                 w_db_done;
  logic                 w_step_req;
  logic                 w_mode_chg;
  logic                 w_rom_chg;
  logic                 w_toggle;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [HC_W-1:0]      w_hc_next;

  assign w_man_s    = r_man_sync[1];
  assign w_mode_s   = r_mode_sync[1];
  assign w_rom_s    = r_rom_sync[1];
  assign w_db_diff  = w_man_s ^ r_db_q;
  assign w_db_done  = w_db_diff && (r_db_cnt == DB_LAST);
  assign w_step_req = w_db_done && !r_db_q;
  assign w_mode_chg = w_mode_s ^ r_mode_prev;
  assign w_rom_chg  = w_rom_s ^ r_rom_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_man_sync  <= '0;
      r_mode_sync <= '0;
      r_rom_sync  <= '0;
      r_mode_prev <= 1'b0;
      r_rom_prev  <= 1'b0;
      r_db_cnt    <= '0;
      r_db_q      <= 1'b0;
    end else begin
      r_man_sync  <= {r_man_sync[0], clk_manual};
      r_mode_sync <= {r_mode_sync[0], single_step_mode};
      r_rom_sync  <= {r_rom_sync[0], rom_selector};
      r_mode_prev <= w_mode_s;
      r_rom_prev  <= w_rom_s;
      if (w_db_done) begin
        r_db_q   <= ~r_db_q;
        r_db_cnt <= '0;
      end else if (w_db_diff) begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_cnt_next = r_cnt;
    w_toggle   = 1'b0;
    if (w_mode_chg) begin
      w_cnt_next = '0;
    end else if (w_mode_s) begin
      w_cnt_next = '0;
      w_toggle   = w_step_req;
    end else if (r_cnt >= cpu_speed) begin
      w_cnt_next = '0;
      w_toggle   = 1'b1;
    end else begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end
  end

  // A rom_selector change reload takes priority over a coincident rise decrement.
  always_comb begin
    w_hc_next = r_hc;
    if (w_rom_chg) begin
      w_hc_next = HC_INIT;
    end else if (r_clk_cpu_rise && (r_hc != '0)) begin
      w_hc_next = r_hc - HC_W'(1);
    end
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_cnt          <= '0;
      r_clk_cpu      <= 1'b0;
      r_clk_cpu_rise <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_clk_cpu      <= r_clk_cpu ^ w_toggle;
      r_clk_cpu_rise <= w_toggle && !r_clk_cpu;
    end
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_hc         <= HC_INIT;
      r_cpu_rst    <= 1'b1;
      r_step_count <= '0;
    end else begin
      r_hc      <= w_hc_next;
      r_cpu_rst <= (w_hc_next != '0);
      if (r_cpu_rst) begin
        r_step_count <= '0;
      end else if (r_clk_cpu_rise) begin
        r_step_count <= r_step_count + 16'd1;
      end
    end
  end

  assign clk_cpu      = r_clk_cpu;
  assign clk_cpu_rise = r_clk_cpu_rise;
  assign cpu_rst      = r_cpu_rst;
  assign step_count   = r_step_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: stimulus queues expected clk_cpu toggles (cycle, level,
// optional cpu_rst/step_count); a negedge monitor pops and compares each toggle.
module tb_cpu_clk_ctrl;

  localparam int CW = 25;

  logic          clk50M = 1'b0;
  logic          rst = 1'b0;
  logic          clk_manual = 1'b0;
  logic          single_step_mode = 1'b0;
  logic [CW-1:0] cpu_speed = '0;
  logic          rom_selector = 1'b0;
  logic          clk_cpu;
  logic          clk_cpu_rise;
  logic          cpu_rst;
  logic [15:0]   step_count;

  typedef struct {
    int cyc;
    bit val;
    bit chk;
    bit rst;
    int sc;
  } exp_t;

  exp_t q_exp[$];
  int   cyc = 0;
  int   base = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_clk = 1'b0;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH      (CW),
    .RST_HOLD       (4)
  ) dut (
    .clk50M          (clk50M),
    .rst             (rst),
    .clk_manual      (clk_manual),
    .single_step_mode(single_step_mode),
    .cpu_speed       (cpu_speed),
    .rom_selector    (rom_selector),
    .clk_cpu         (clk_cpu),
    .clk_cpu_rise    (clk_cpu_rise),
    .cpu_rst         (cpu_rst),
    .step_count      (step_count)
  );

  always #5 clk50M = ~clk50M;
  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int o, input bit v);
    exp_t e;
    e.cyc = base + o;
    e.val = v;
    e.chk = 1'b0;
    e.rst = 1'b0;
    e.sc  = 0;
    q_exp.push_back(e);
  endtask

  // Toggles at o_first, o_first+step, ... starting from clk_cpu=0.
  task automatic push_run(input int o_first, input int o_last, input int step);
    for (int o = o_first; o <= o_last; o += step)
      push(o, (((o - o_first) / step) % 2) == 0);
  endtask

  task automatic mark(input int o, input bit r, input int sc);
    for (int i = 0; i < q_exp.size(); i++) begin
      if (q_exp[i].cyc == base + o) begin
        q_exp[i].chk = 1'b1;
        q_exp[i].rst = r;
        q_exp[i].sc  = sc;
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk50M);
  endtask

  task automatic do_release();
    repeat (2) @(negedge clk50M);
    rst  = 1'b1;
    base = cyc;
  endtask

  // Asserts rst just after the monitor has handled the last expected toggle.
  task automatic end_phase(input int o);
    wait_cyc(base + o);
    #2;
    rst = 1'b0;
    check("queue_drained", q_exp.size(), 0);
    q_exp.delete();
  endtask

  always @(negedge clk50M) begin
    exp_t e;
    if (!rst) begin
      last_clk = clk_cpu;
    end else if (clk_cpu !== last_clk) begin
      if (q_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_toggle @cyc %0d: got clk_cpu=%b, want no toggle", cyc, clk_cpu);
      end else begin
        e = q_exp.pop_front();
        check("toggle_cycle", cyc, e.cyc);
        check("clk_cpu", clk_cpu, e.val);
        check("clk_cpu_rise", clk_cpu_rise, e.val);
        if (e.chk) begin
          check("cpu_rst", cpu_rst, e.rst);
          check("step_count", step_count, e.sc);
        end
      end
      last_clk = clk_cpu;
    end else if (clk_cpu_rise) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_rise @cyc %0d: got clk_cpu_rise=1, want 0", cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog @cyc %0d: got timeout, want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk50M);
    check("rst_clk_cpu", clk_cpu, 0);
    check("rst_clk_cpu_rise", clk_cpu_rise, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_step_count", step_count, 0);

    // Free-run cpu_speed=3: period 8, cpu_rst falls after 4th rise
    cpu_speed = 3;
    do_release();
    push_run(4, 44, 4);
    mark(4, 1, 0);
    mark(28, 1, 0);
    mark(32, 0, 0);
    mark(36, 0, 0);
    mark(44, 0, 1);
    end_phase(44);

    // cpu_speed=0, then 10 at count 0, then 2 at count 7
    cpu_speed = 0;
    do_release();
    push_run(1, 6, 1);
    mark(6, 1, 0);
    wait_cyc(base + 6);
    cpu_speed = 10;
    wait_cyc(base + 13);
    cpu_speed = 2;
    push_run(14, 23, 3);
    mark(14, 1, 0);
    mark(17, 0, 0);
    mark(20, 0, 0);
    mark(23, 0, 1);
    end_phase(23);

    // Single-step: short pulse, held press, bouncy press
    single_step_mode = 1'b1;
    cpu_speed = 100;
    do_release();
    wait_cyc(base + 5);
    clk_manual = 1'b1;
    wait_cyc(base + 10);
    clk_manual = 1'b0;
    wait_cyc(base + 25);
    clk_manual = 1'b1;
    push(35, 1'b1);
    mark(35, 1, 0);
    wait_cyc(base + 45);
    clk_manual = 1'b0;
    wait_cyc(base + 70);
    clk_manual = 1'b1;
    push(85, 1'b0);
    mark(85, 1, 0);
    wait_cyc(base + 73);
    clk_manual = 1'b0;
    wait_cyc(base + 75);
    clk_manual = 1'b1;
    wait_cyc(base + 87);
    clk_manual = 1'b0;
    end_phase(100);

    // Mode change free-run -> single-step with clk_cpu=1 mid-count
    single_step_mode = 1'b0;
    cpu_speed = 5;
    do_release();
    push_run(6, 18, 6);
    wait_cyc(base + 19);
    single_step_mode = 1'b1;
    wait_cyc(base + 30);
    check("mode_chg_clk_level", clk_cpu, 1);
    check("mode_chg_count", dut.r_cnt, 0);
    clk_manual = 1'b1;
    push(40, 1'b0);
    mark(40, 1, 0);
    end_phase(45);
    clk_manual = 1'b0;

    // rom_selector toggles during free-run at step_count=37
    single_step_mode = 1'b0;
    cpu_speed = 1;
    do_release();
    push_run(2, 196, 2);
    mark(14, 1, 0);
    mark(16, 0, 0);
    mark(162, 0, 36);
    mark(164, 0, 37);
    mark(166, 0, 37);
    mark(168, 1, 0);
    mark(184, 1, 0);
    mark(188, 1, 0);
    mark(190, 1, 0);
    mark(192, 0, 0);
    mark(194, 0, 0);
    mark(196, 0, 1);
    wait_cyc(base + 164);
    rom_selector = 1'b1;
    wait_cyc(base + 167);
    check("rom_cpu_rst", cpu_rst, 1);
    check("rom_step_count_last", step_count, 38);
    wait_cyc(base + 172);
    rom_selector = 1'b0;
    wait_cyc(base + 175);
    check("rom_reload_hc", dut.r_hc, 4);
    end_phase(196);

    // Async rst mid-operation with clk_cpu=1, step_count=100
    cpu_speed = 0;
    do_release();
    push_run(1, 209, 1);
    mark(7, 1, 0);
    mark(8, 0, 0);
    mark(9, 0, 0);
    mark(11, 0, 1);
    mark(209, 0, 100);
    end_phase(209);
    #1;
    check("async_clk_cpu", clk_cpu, 0);
    check("async_cpu_rst", cpu_rst, 1);
    check("async_step_count", step_count, 0);
    check("async_clk_cpu_rise", clk_cpu_rise, 0);
    do_release();
    push_run(1, 8, 1);
    mark(1, 1, 0);
    mark(7, 1, 0);
    mark(8, 0, 0);
    end_phase(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
